// File: rtl/rv_pkg.sv
// rv_pkg: shared RV32I widths, register-address typedefs and the x0 constant.
// Revision 1.0
`default_nettype none

package rv_pkg;
  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]   word_t;

  localparam reg_addr_t REG_ZERO = 5'd0;
endpackage

`default_nettype wire

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register pending-load bits and load-use stall compare.
// Optional macro REGFILE_BYPASS_EN lets a same-cycle write-back suppress the stall. Revision 1.0
`default_nettype none

module reg_scoreboard #(
  parameter int NREG = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [rv_pkg::REG_AW-1:0] rs1_addr,
  input  logic [rv_pkg::REG_AW-1:0] rs2_addr,
  input  logic                      rs1_used,
  input  logic                      rs2_used,
  input  logic                      RegWrite,
  input  logic [rv_pkg::REG_AW-1:0] wr_addr,
  input  logic                      busy_set,
  input  logic [rv_pkg::REG_AW-1:0] busy_addr,
  output logic                      stall
);
  import rv_pkg::*;

  logic [NREG-1:1] busy;
  logic [NREG-1:0] busy_vec;
  logic            byp1;
  logic            byp2;
  logic            haz1;
  logic            haz2;

  // A new load issuing to a register whose older load is retiring keeps it busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      for (int i = 1; i < NREG; i++) begin
        if (busy_set && busy_addr == REG_AW'(i))
          busy[i] <= 1'b1;
        else if (RegWrite && wr_addr == REG_AW'(i))
          busy[i] <= 1'b0;
      end
    end
  end

  assign busy_vec = {busy, 1'b0};

`ifdef REGFILE_BYPASS_EN
  assign byp1 = RegWrite && (wr_addr != REG_ZERO) && (wr_addr == rs1_addr);
  assign byp2 = RegWrite && (wr_addr != REG_ZERO) && (wr_addr == rs2_addr);
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  assign haz1  = rs1_used && (rs1_addr != REG_ZERO) && busy_vec[rs1_addr] && !byp1;
  assign haz2  = rs2_used && (rs2_addr != REG_ZERO) && busy_vec[rs2_addr] && !byp2;
  assign stall = haz1 | haz2;

endmodule

`default_nettype wire

// File: rtl/reg_file.sv
// reg_file: RV32I architectural register file, two combinational reads, one write, load-use stall.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle Write_data to the read ports. Revision 1.0
`default_nettype none

module reg_file #(
  parameter int XLEN = rv_pkg::XLEN,
  parameter int NREG = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [rv_pkg::REG_AW-1:0] rs1_addr,
  input  logic [rv_pkg::REG_AW-1:0] rs2_addr,
  input  logic                      rs1_used,
  input  logic                      rs2_used,
  output logic [XLEN-1:0]           rs1_data,
  output logic [XLEN-1:0]           rs2_data,
  input  logic                      RegWrite,
  input  logic [rv_pkg::REG_AW-1:0] wr_addr,
  input  logic [XLEN-1:0]           Write_data,
  input  logic                      busy_set,
  input  logic [rv_pkg::REG_AW-1:0] busy_addr,
  output logic                      stall
);
  import rv_pkg::*;

  logic [XLEN-1:0] mem [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++)
        mem[i] <= '0;
    end else if (RegWrite && wr_addr != REG_ZERO) begin
      mem[wr_addr] <= Write_data;
    end
  end

  always_comb begin
    rs1_data = (rs1_addr == REG_ZERO) ? '0 : mem[rs1_addr];
    rs2_data = (rs2_addr == REG_ZERO) ? '0 : mem[rs2_addr];
`ifdef REGFILE_BYPASS_EN
    if (RegWrite && wr_addr != REG_ZERO && wr_addr == rs1_addr)
      rs1_data = Write_data;
    if (RegWrite && wr_addr != REG_ZERO && wr_addr == rs2_addr)
      rs2_data = Write_data;
`endif
  end

  reg_scoreboard #(
    .NREG(NREG)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .rs1_used (rs1_used),
    .rs2_used (rs2_used),
    .RegWrite (RegWrite),
    .wr_addr  (wr_addr),
    .busy_set (busy_set),
    .busy_addr(busy_addr),
    .stall    (stall)
  );

endmodule

`default_nettype wire

// File: tb/tb_reg_file.sv
// tb_reg_file: scenario tasks push expected values to a queue and pop them when sampling the DUT.
// Revision 1.0
`default_nettype none

module tb_reg_file;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [4:0]  rs1_addr, rs2_addr, wr_addr, busy_addr;
  logic        rs1_used, rs2_used, RegWrite, busy_set;
  logic [31:0] Write_data;
  logic [31:0] rs1_data, rs2_data;
  logic        stall;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] e;

  reg_file dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rs1_addr  (rs1_addr),
    .rs2_addr  (rs2_addr),
    .rs1_used  (rs1_used),
    .rs2_used  (rs2_used),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .RegWrite  (RegWrite),
    .wr_addr   (wr_addr),
    .Write_data(Write_data),
    .busy_set  (busy_set),
    .busy_addr (busy_addr),
    .stall     (stall)
  );

  always #5 clk = ~clk;

  task automatic idle();
    rs1_addr = 0; rs2_addr = 0; rs1_used = 0; rs2_used = 0;
    RegWrite = 0; wr_addr = 0; Write_data = 0; busy_set = 0; busy_addr = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    rs1_addr = 5'd5; rs2_addr = 5'd6; rs1_used = 1; rs2_used = 1;
    #1 rst_n = 1'b0;
    #2;
    exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    e = exp_q.pop_front(); checks++;
    if (rs1_data !== e) begin errors++; $display("FAIL reset_rs1 got %h want %h", rs1_data, e); end
    e = exp_q.pop_front(); checks++;
    if (rs2_data !== e) begin errors++; $display("FAIL reset_rs2 got %h want %h", rs2_data, e); end
    e = exp_q.pop_front(); checks++;
    if (stall !== e[0]) begin errors++; $display("FAIL reset_stall got %b want %b", stall, e[0]); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_write_read();
    idle();
    RegWrite = 1; wr_addr = 5'd5; Write_data = 32'hDEADBEEF;
    exp_q.push_back(32'hDEADBEEF);
    tick();
    RegWrite = 1; wr_addr = 5'd6; Write_data = 32'h0F0F1234;
    rs1_addr = 5'd5; rs1_used = 1;
    exp_q.push_back(32'h0);
    #2;
    e = exp_q.pop_front(); checks++;
    if (rs1_data !== e) begin errors++; $display("FAIL wr_rd_x5 got %h want %h", rs1_data, e); end
    e = exp_q.pop_front(); checks++;
    if (stall !== e[0]) begin errors++; $display("FAIL wr_rd_stall got %b want %b", stall, e[0]); end
    tick();
    idle();
    rs1_addr = 5'd6; rs2_addr = 5'd6;
    exp_q.push_back(32'h0F0F1234); exp_q.push_back(32'h0F0F1234);
    #2;
    e = exp_q.pop_front(); checks++;
    if (rs1_data !== e) begin errors++; $display("FAIL same_addr_rs1 got %h want %h", rs1_data, e); end
    e = exp_q.pop_front(); checks++;
    if (rs2_data !== e) begin errors++; $display("FAIL same_addr_rs2 got %h want %h", rs2_data, e); end
    tick();
  endtask

  task automatic test_x0();
    idle();
    RegWrite = 1; wr_addr = 5'd0; Write_data = 32'h12345678;
    busy_set = 1; busy_addr = 5'd0;
    tick();
    idle();
    rs1_used = 1; rs2_used = 1;
    exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    #2;
    e = exp_q.pop_front(); checks++;
    if (rs1_data !== e) begin errors++; $display("FAIL x0_rs1 got %h want %h", rs1_data, e); end
    e = exp_q.pop_front(); checks++;
    if (rs2_data !== e) begin errors++; $display("FAIL x0_rs2 got %h want %h", rs2_data, e); end
    e = exp_q.pop_front(); checks++;
    if (stall !== e[0]) begin errors++; $display("FAIL x0_busy_stall got %b want %b", stall, e[0]); end
    tick();
  endtask

  task automatic test_load_use();
    idle();
    busy_set = 1; busy_addr = 5'd7;
    rs2_addr = 5'd7; rs2_used = 1;
    exp_q.push_back(32'h0);
    #2;
    e = exp_q.pop_front(); checks++;
    if (stall !== e[0]) begin errors++; $display("FAIL lu_set_cycle got %b want %b", stall, e[0]); end
    tick();
    busy_set = 0;
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(32'h1);
      #2;
      e = exp_q.pop_front(); checks++;
      if (stall !== e[0]) begin errors++; $display("FAIL lu_wait%0d got %b want %b", k, stall, e[0]); end
      tick();
    end
    RegWrite = 1; wr_addr = 5'd7; Write_data = 32'hA5A5A5A5;
`ifdef REGFILE_BYPASS_EN
    exp_q.push_back(32'h0); exp_q.push_back(32'hA5A5A5A5);
`else
    exp_q.push_back(32'h1); exp_q.push_back(32'h0);
`endif
    #2;
    e = exp_q.pop_front(); checks++;
    if (stall !== e[0]) begin errors++; $display("FAIL lu_wb_stall got %b want %b", stall, e[0]); end
    e = exp_q.pop_front(); checks++;
    if (rs2_data !== e) begin errors++; $display("FAIL lu_wb_data got %h want %h", rs2_data, e); end
    tick();
    RegWrite = 0;
    exp_q.push_back(32'h0); exp_q.push_back(32'hA5A5A5A5);
    #2;
    e = exp_q.pop_front(); checks++;
    if (stall !== e[0]) begin errors++; $display("FAIL lu_after_stall got %b want %b", stall, e[0]); end
    e = exp_q.pop_front(); checks++;
    if (rs2_data !== e) begin errors++; $display("FAIL lu_after_data got %h want %h", rs2_data, e); end
    tick();
  endtask

  task automatic test_set_wins();
    idle();
    busy_set = 1; busy_addr = 5'd9;
    tick();
    RegWrite = 1; wr_addr = 5'd9; Write_data = 32'h00000099;
    tick();
    idle();
    rs1_addr = 5'd9; rs1_used = 1;
    exp_q.push_back(32'h1); exp_q.push_back(32'h00000099);
    #2;
    e = exp_q.pop_front(); checks++;
    if (stall !== e[0]) begin errors++; $display("FAIL set_wins_stall got %b want %b", stall, e[0]); end
    e = exp_q.pop_front(); checks++;
    if (rs1_data !== e) begin errors++; $display("FAIL set_wins_data got %h want %h", rs1_data, e); end
    tick();
  endtask

  task automatic test_unused();
    idle();
    busy_set = 1; busy_addr = 5'd3;
    tick();
    idle();
    rs1_addr = 5'd3; rs1_used = 0;
    exp_q.push_back(32'h0);
    #2;
    e = exp_q.pop_front(); checks++;
    if (stall !== e[0]) begin errors++; $display("FAIL unused_stall got %b want %b", stall, e[0]); end
    rs1_used = 1;
    exp_q.push_back(32'h1);
    #1;
    e = exp_q.pop_front(); checks++;
    if (stall !== e[0]) begin errors++; $display("FAIL used_stall got %b want %b", stall, e[0]); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] prev;
    idle();
    for (int k = 0; k < 5; k++) begin
      RegWrite = 1; wr_addr = 5'(10 + k); Write_data = 32'hC0DE0000 + 32'(k * 257);
      if (k > 0) begin
        rs1_addr = 5'(10 + k - 1);
        rs2_addr = 5'(10 + k - 1);
        #2;
        e = exp_q.pop_front(); checks++;
        if (rs1_data !== e) begin errors++; $display("FAIL b2b_x%0d got %h want %h", 10 + k - 1, rs1_data, e); end
        checks++;
        if (rs2_data !== e) begin errors++; $display("FAIL b2b2_x%0d got %h want %h", 10 + k - 1, rs2_data, e); end
      end
      prev = Write_data;
      exp_q.push_back(prev);
      tick();
    end
    idle();
    rs1_addr = 5'd14;
    #2;
    e = exp_q.pop_front(); checks++;
    if (rs1_data !== e) begin errors++; $display("FAIL b2b_x14 got %h want %h", rs1_data, e); end
    tick();
  endtask

  task automatic test_async_reset();
    idle();
    RegWrite = 1; wr_addr = 5'd4; Write_data = 32'h55;
    tick();
    idle();
    busy_set = 1; busy_addr = 5'd4;
    tick();
    idle();
    rs1_addr = 5'd4; rs1_used = 1;
    exp_q.push_back(32'h1); exp_q.push_back(32'h55);
    #2;
    e = exp_q.pop_front(); checks++;
    if (stall !== e[0]) begin errors++; $display("FAIL arst_pre_stall got %b want %b", stall, e[0]); end
    e = exp_q.pop_front(); checks++;
    if (rs1_data !== e) begin errors++; $display("FAIL arst_pre_data got %h want %h", rs1_data, e); end
    #1 rst_n = 1'b0;
    exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    #1;
    e = exp_q.pop_front(); checks++;
    if (stall !== e[0]) begin errors++; $display("FAIL arst_stall got %b want %b", stall, e[0]); end
    e = exp_q.pop_front(); checks++;
    if (rs1_data !== e) begin errors++; $display("FAIL arst_data got %h want %h", rs1_data, e); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    idle();
    test_reset();
    test_write_read();
    test_x0();
    test_load_use();
    test_set_wins();
    test_unused();
    test_back_to_back();
    test_async_reset();
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain got %0d want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/reg_file.md
# reg_file

Architectural integer register file for the five-stage RV32I pipeline. It is the read-side counterpart of the write-back stage: it stores the `Write_data` produced by write-back and serves the two source-operand reads issued by decode. It also holds a per-register pending-load scoreboard, so decode can stall on a load-use hazard until the load's write-back lands.

## Interface
Parameters:
- `XLEN`, 32, data width.
- `NREG`, 32, number of registers. Address width is `$clog2(NREG)` = 5.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `rs1_addr` in 5: decode source 1 address.
- `rs2_addr` in 5: decode source 2 address.
- `rs1_used` in 1: instruction in decode actually reads rs1.
- `rs2_used` in 1: instruction in decode actually reads rs2.
- `rs1_data` out XLEN: source 1 operand, combinational.
- `rs2_data` out XLEN: source 2 operand, combinational.
- `RegWrite` in 1: write-back write enable.
- `wr_addr` in 5: write-back destination.
- `Write_data` in XLEN: write-back value.
- `busy_set` in 1: a load leaving decode this cycle marks its rd pending.
- `busy_addr` in 5: rd of that load.
- `stall` out 1: decode must hold; combinational.

## Operation
- Storage is `NREG` x `XLEN` flops.
- Register 0:
  - Writes to it are discarded.
  - Reads of it return 0.
  - It is never marked busy.
- Write: on rising edge, if `RegWrite` and `wr_addr != 0`, then `mem[wr_addr] <= Write_data`.
- Read: `rsN_data = (rsN_addr == 0) ? 0 : mem[rsN_addr]`, with a bypass override (see Configuration).
- Scoreboard: `busy[NREG-1:1]`, one bit per register.
  - Set on an edge when `busy_set && busy_addr != 0`.
  - Cleared on an edge when `RegWrite && wr_addr` matches a busy bit.
  - Set and clear of the same index in the same cycle: **set wins**, because a new load was issued while the older write retires.
- Stall: `stall = hazN(rs1) | hazN(rs2)`.
  - `hazN` = `rsN_used && rsN_addr != 0 && busy[rsN_addr] && !bypass_hit(rsN)`.
  - `bypass_hit` is only ever true when `REGFILE_BYPASS_EN` is defined.
- Same address on rs1 and rs2: both ports return the identical value.
- `busy_set` with `busy_addr` equal to an already-busy register: the bit stays 1. There is no counting; the pipeline allows only one outstanding load per rd.

## Timing
- Read latency 0: data is valid in the same cycle the address is applied.
- Write latency 1: a write is visible through the array the cycle after the `RegWrite` edge.
- Scoreboard update latency 1: `stall` reflects `busy_set` from the cycle after the set.
- Reset (async assert, `rst_n` = 0):
  - All `mem` entries = 0 and all `busy` bits = 0.
  - Outputs therefore read `rs1_data` = `rs2_data` = 0 and `stall` = 0.
  - Reset asserted mid-load: the pending state is lost. This is correct because the pipeline is flushed by the same reset.
- Deassertion is taken synchronously by the surrounding reset synchronizer; there is no requirement inside this block.

## Configuration
- `REGFILE_BYPASS_EN` **defined** (write-through):
  - If `RegWrite && wr_addr != 0 && wr_addr == rsN_addr`, then `rsN_data = Write_data` in the same cycle.
  - `bypass_hit(rsN)` is true in that case, which suppresses the stall for that source. A load-use gap therefore costs exactly 1 stall cycle less.
- `REGFILE_BYPASS_EN` **undefined**:
  - Reads return the pre-edge array value.
  - `stall` stays asserted through the write-back cycle and releases the cycle after.

## Structure
- Shared package `rv_pkg`: `XLEN`, `REG_AW`, `REG_ZERO` (5'd0), and the `reg_addr_t` / `word_t` typedefs. Write-back and decode import the same package.
- One sub-module, `reg_scoreboard`: holds the busy bits, the set/clear priority and the hazard compare. It takes the two read addresses, the `used` flags, the write port and the set port, and outputs `stall`.
- The array and the read muxes stay in `reg_file`.

## Test plan
- Reset, then write 0xDEADBEEF to x5 and read rs1=x5 the next cycle: `rs1_data` = 0xDEADBEEF, `stall` = 0.
- Write 0x12345678 to x0, then read rs1=rs2=x0: both outputs = 0. Also `busy_set` with `busy_addr`=0: `stall` stays 0.
- `busy_set` for x7, then decode with rs2=x7 and `rs2_used`=1: `stall` = 1 each cycle until `RegWrite` x7 = 0xA5A5A5A5.
  - With the macro: `stall` = 0 in the write cycle and `rs2_data` = 0xA5A5A5A5.
  - Without the macro: `stall` = 1 in the write cycle, then 0 with the data the cycle after.
- Same-cycle `busy_set` x9 and `RegWrite` x9 (older load retiring): x9 stays busy and `stall` = 1 for a reader of x9 the next cycle.
- Busy x3 with rs1=x3 but `rs1_used`=0: `stall` = 0.
- Assert `rst_n` low asynchronously mid-cycle while x4 is busy and holds 0x55: `stall` = 0 and reads of x4 = 0 immediately, with no clock edge required.
